// File: rtl/pipelined_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_control_unit_pkg
// Brief    : Opcodes, ALUOp encodings and control-bundle layout for the
//            ID-stage main control of the pipelined RISC-V core.
// Revision : 1.0
// ============================================================================
package pipelined_control_unit_pkg;

    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_IALU  = 7'b0010011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;

    localparam logic [1:0] c_ALUOP_ADD = 2'b00;
    localparam logic [1:0] c_ALUOP_BR  = 2'b01;
    localparam logic [1:0] c_ALUOP_R   = 2'b10;
    localparam logic [1:0] c_ALUOP_I   = 2'b11;

    // Field order is the packing order used wherever the bundle is flattened.
    typedef struct packed {
        logic branch;
        logic memread;
        logic memtoreg;
        logic memwrite;
        logic alusrc;
        logic regwrite;
        logic jump;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/pipelined_control_unit_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Brief    : Combinational opcode decode into the control bundle, ALUOp and
//            register-usage / illegal flags.
// Revision : 1.0
// ============================================================================
module ctrl_decode
    import pipelined_control_unit_pkg::*;
#(
    parameter int ALUOP_W     = 2,
    parameter int ENABLE_JUMP = 1
) (
    input  logic [6:0]         i_opcode,
    output ctrl_t              o_ctrl,
    output logic [ALUOP_W-1:0] o_aluop,
    output logic               o_uses_rs1,
    output logic               o_uses_rs2,
    output logic               o_illegal
);

    logic [1:0] w_aluop_code;

    always_comb begin
        o_ctrl       = '0;
        w_aluop_code = c_ALUOP_ADD;
        o_uses_rs1   = 1'b0;
        o_uses_rs2   = 1'b0;
        o_illegal    = 1'b0;
        case (i_opcode)
            c_OP_R: begin
                o_ctrl.regwrite = 1'b1;
                w_aluop_code    = c_ALUOP_R;
                o_uses_rs1      = 1'b1;
                o_uses_rs2      = 1'b1;
            end
            c_OP_LOAD: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.memtoreg = 1'b1;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.memread  = 1'b1;
                o_uses_rs1      = 1'b1;
            end
            c_OP_STORE: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.memwrite = 1'b1;
                o_uses_rs1      = 1'b1;
                o_uses_rs2      = 1'b1;
            end
            c_OP_BR: begin
                o_ctrl.branch = 1'b1;
                w_aluop_code  = c_ALUOP_BR;
                o_uses_rs1    = 1'b1;
                o_uses_rs2    = 1'b1;
            end
            c_OP_IALU: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.regwrite = 1'b1;
                w_aluop_code    = c_ALUOP_I;
                o_uses_rs1      = 1'b1;
            end
            // JAL carries immediate bits in the rs1 field, so it never reads rs1.
            c_OP_JAL: begin
                if (ENABLE_JUMP != 0) begin
                    o_ctrl.jump     = 1'b1;
                    o_ctrl.regwrite = 1'b1;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            c_OP_JALR: begin
                if (ENABLE_JUMP != 0) begin
                    o_ctrl.jump     = 1'b1;
                    o_ctrl.regwrite = 1'b1;
                    o_ctrl.alusrc   = 1'b1;
                    o_uses_rs1      = 1'b1;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            default: o_illegal = 1'b1;
        endcase
    end

    assign o_aluop = ALUOP_W'(w_aluop_code);

endmodule
`default_nettype wire

// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_control_unit
// Brief    : ID-stage main control with load-use hazard detection, flush
//            squashing, ID/EX control register and illegal-opcode counter.
// Revision : 1.0
// ============================================================================
module pipelined_control_unit
    import pipelined_control_unit_pkg::*;
#(
    parameter int ALUOP_W     = 2,
    parameter int REG_ADDR_W  = 5,
    parameter int ENABLE_JUMP = 1,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [31:0]           id_instr,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  ex_valid,
    output logic                  ex_branch,
    output logic                  ex_memread,
    output logic                  ex_memtoreg,
    output logic                  ex_memwrite,
    output logic                  ex_alusrc,
    output logic                  ex_regwrite,
    output logic                  ex_jump,
    output logic [ALUOP_W-1:0]    ex_aluop,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic                  illegal_o,
    output logic [CNT_W-1:0]      illegal_cnt
);

    ctrl_t                  w_ctrl;
    logic [ALUOP_W-1:0]     w_aluop;
    logic                   w_uses_rs1;
    logic                   w_uses_rs2;
    logic                   w_illegal;
    logic [REG_ADDR_W-1:0]  w_rd;
    logic [REG_ADDR_W-1:0]  w_rs1;
    logic [REG_ADDR_W-1:0]  w_rs2;
    logic                   w_stall;
    logic                   w_accept;
    logic                   w_unused_bits;

    ctrl_t                  r_ctrl;
    logic [ALUOP_W-1:0]     r_aluop;
    logic                   r_valid;
    logic [REG_ADDR_W-1:0]  r_rd;
    logic [REG_ADDR_W-1:0]  r_rs1;
    logic [REG_ADDR_W-1:0]  r_rs2;
    logic                   r_illegal;
    logic [CNT_W-1:0]       r_cnt;

    ctrl_decode #(
        .ALUOP_W     (ALUOP_W),
        .ENABLE_JUMP (ENABLE_JUMP)
    ) u_ctrl_decode (
        .i_opcode   (id_instr[6:0]),
        .o_ctrl     (w_ctrl),
        .o_aluop    (w_aluop),
        .o_uses_rs1 (w_uses_rs1),
        .o_uses_rs2 (w_uses_rs2),
        .o_illegal  (w_illegal)
    );

    assign w_rd          = REG_ADDR_W'(id_instr[11:7]);
    assign w_rs1         = REG_ADDR_W'(id_instr[19:15]);
    assign w_rs2         = REG_ADDR_W'(id_instr[24:20]);
    assign w_unused_bits = ^{id_instr[31:25], id_instr[14:12]};

    // Only a load still sitting in EX can supply a value too late for ID.
    assign w_stall = id_valid & ~flush_i & r_valid & r_ctrl.memread
                   & (r_rd != '0)
                   & ((w_uses_rs1 & (r_rd == w_rs1)) | (w_uses_rs2 & (r_rd == w_rs2)));

    assign w_accept = id_valid & ~flush_i & ~w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl    <= '0;
            r_aluop   <= '0;
            r_valid   <= 1'b0;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_ctrl  <= w_ctrl;
                r_aluop <= w_aluop;
                r_valid <= 1'b1;
                r_rd    <= w_rd;
                r_rs1   <= w_rs1;
                r_rs2   <= w_rs2;
            end else begin
                r_ctrl  <= '0;
                r_aluop <= '0;
                r_valid <= 1'b0;
                r_rd    <= '0;
                r_rs1   <= '0;
                r_rs2   <= '0;
            end
            r_illegal <= w_accept & w_illegal;
            if (w_accept && w_illegal && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_o     = w_stall;
    assign ex_valid    = r_valid;
    assign ex_branch   = r_ctrl.branch;
    assign ex_memread  = r_ctrl.memread;
    assign ex_memtoreg = r_ctrl.memtoreg;
    assign ex_memwrite = r_ctrl.memwrite;
    assign ex_alusrc   = r_ctrl.alusrc;
    assign ex_regwrite = r_ctrl.regwrite;
    assign ex_jump     = r_ctrl.jump;
    assign ex_aluop    = r_aluop;
    assign ex_rd       = r_rd;
    assign ex_rs1      = r_rs1;
    assign ex_rs2      = r_rs2;
    assign illegal_o   = r_illegal;
    assign illegal_cnt = r_cnt;

endmodule
`default_nettype wire
